// File: rtl/cos_sweep_pkg.sv
// rtl/cos_sweep_pkg.sv - shared state enum, word format constants and FIFO entry type for the cosine sweep
package cos_sweep_pkg;

    localparam int DEF_W     = 25;
    localparam int FRAC_BITS = 23;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } state_t;

    typedef struct packed {
        logic [DEF_W-1:0] angle;
        logic [DEF_W-1:0] cos;
    } fifo_entry_t;

endpackage

// File: rtl/sweep_fifo.sv
// rtl/sweep_fifo.sv - synchronous result FIFO with full/empty flags and a zero-masked head
module sweep_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    // DEPTH must be a power of two, at least 2; the pointers carry one extra wrap bit.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is left unreset, so the head is forced to zero whenever nothing valid is held.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Write the pushed entry into the slot under the write pointer.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Advance pointers; simultaneous push and pop both take effect.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cos_sweep_ctrl.sv
// rtl/cos_sweep_ctrl.sv - angle sweep sequencer for a cosine core; core watchdog enabled by SWEEP_TIMEOUT_EN
module cos_sweep_ctrl
    import cos_sweep_pkg::*;
#(
    parameter int W              = DEF_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         run,
    input  logic [W-1:0] step_in,
    input  logic [W-1:0] limit_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [15:0]  count,
    output logic         core_start,
    output logic [W-1:0] core_angle,
    input  logic         core_ready,
    input  logic [W-1:0] core_cos,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_angle,
    output logic [W-1:0] res_cos
);

    // A zero gap degenerates to a single GAP cycle.
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 1) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   step_q;
    logic [W-1:0]   limit_q;
    logic [15:0]    gap_cnt;
    logic           ready_q;
    logic           done_q;
    logic           rise;
    logic           accept;
    logic           push;
    logic           advance;
    logic           tmo_hit;
    logic [W:0]     next_sum;
    logic           step_bad;
    logic           fifo_full;
    logic           fifo_empty;
    logic [2*W-1:0] fifo_head;

    assign rise     = core_ready & ~ready_q;
    assign next_sum = {1'b0, core_angle} + {1'b0, step_q};
    assign step_bad = (step_in == '0) || (step_in > limit_in);
    assign busy     = (state != IDLE);
    assign done     = done_q;

`ifdef SWEEP_TIMEOUT_EN
    // Leaving WAIT at this count puts the done pulse exactly TIMEOUT_CYCLES after core_start,
    // since FIN and the done register each add one cycle.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 2);
    logic [15:0] tmo_cnt;
    logic        err_q;

    // Watchdog: tmo_cnt equals the number of cycles since core_start while in WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt <= 16'd1;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT) ? tmo_cnt + 16'd1 : 16'd1;
            if (accept) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and one-cycle control strobes.
    always_comb begin
        state_next = state;
        core_start = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        advance    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    accept     = 1'b1;
                    state_next = step_bad ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                // Holding here while full guarantees the later push always has room.
                if (!fifo_full) begin
                    core_start = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (rise) begin
                    push       = 1'b1;
                    state_next = GAP;
                end
`ifdef SWEEP_TIMEOUT_EN
                else if (tmo_cnt >= TMO_LAST) begin
                    tmo_hit    = 1'b1;
                    state_next = FIN;
                end
`endif
            end
            GAP: begin
                if (gap_cnt >= GAP_LAST) begin
                    if (next_sum[W] || (next_sum[W-1:0] > limit_q)) begin
                        state_next = FIN;
                    end else begin
                        advance    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: latched operands, current angle, result count, gap timer and edge detector.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_angle <= '0;
            step_q     <= '0;
            limit_q    <= '0;
            count      <= '0;
            gap_cnt    <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ready_q <= core_ready;
            done_q  <= (state == FIN);
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
            if (accept) begin
                core_angle <= step_in;
                step_q     <= step_in;
                limit_q    <= limit_in;
                count      <= '0;
            end
            if (advance) begin
                core_angle <= next_sum[W-1:0];
            end
            if (push && (count != 16'hFFFF)) begin
                count <= count + 16'd1;
            end
        end
    end

    sweep_fifo #(
        .WIDTH (2 * W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({core_angle, core_cos}),
        .pop       (res_valid & res_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_valid = ~fifo_empty;
    assign res_angle = fifo_head[2*W-1:W];
    assign res_cos   = fifo_head[W-1:0];

endmodule

// File: tb/tb_cos_sweep_ctrl.sv
// tb/tb_cos_sweep_ctrl.sv - directed self-checking bench for cos_sweep_ctrl; SWEEP_TIMEOUT_EN adds the watchdog case
module tb_cos_sweep_ctrl;
    import cos_sweep_pkg::*;

    localparam int W = DEF_W;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         run = 1'b0;
    logic [W-1:0] step_in = '0;
    logic [W-1:0] limit_in = '0;
    logic         busy;
    logic         done;
    logic         err;
    logic [15:0]  count;
    logic         core_start;
    logic [W-1:0] core_angle;
    logic         core_ready = 1'b0;
    logic [W-1:0] core_cos = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_angle;
    logic [W-1:0] res_cos;

    int passed = 0;
    int failed = 0;
    int total = 0;
    int cyc = 0;
    int run_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int lat = 0;
    logic hold = 1'b0;
    logic kick = 1'b0;
    fifo_entry_t got[$];

    cos_sweep_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .step_in    (step_in),
        .limit_in   (limit_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_ready (core_ready),
        .core_cos   (core_cos),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_angle  (res_angle),
        .res_cos    (res_cos)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] cos_model(input logic [W-1:0] a);
        logic [W-1:0] one;
        one = 25'd1 << FRAC_BITS;
        return one ^ a;
    endfunction

    // Behavioural core: ready rises 3 cycles after start, or follows kick when held.
    always @(negedge clock) begin
        if (hold) begin
            core_ready = kick;
        end else if (core_start) begin
            core_ready = 1'b0;
            lat = 3;
        end else if (lat != 0) begin
            lat = lat - 1;
            if (lat == 0) begin
                core_ready = 1'b1;
                core_cos = cos_model(core_angle);
            end
        end
    end

    // Observe pulses and stream transfers.
    always @(negedge clock) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (core_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (res_valid && res_ready) begin
            got.push_back('{angle: res_angle, cos: res_cos});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [W-1:0] s, input logic [W-1:0] l);
        step_in = s;
        limit_in = l;
        run = 1'b1;
        run_cyc = cyc;
        tick(1);
        run = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 64'(done_cnt - d0), 64'd1);
        tick(8);
    endtask

    task automatic check_sweep(input string tag, input int n, input logic [W-1:0] s);
        int bad;
        logic [W-1:0] a;
        bad = 0;
        check({tag, "_n"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < got.size(); i++) begin
            a = W'(s * (i + 1));
            if (got[i].angle !== a || got[i].cos !== cos_model(a)) bad++;
        end
        check({tag, "_data"}, 64'(bad), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int s0;
        int d0;
        int start_angle;

        // Reset state
        tick(3);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_core_start", core_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_core_angle", core_angle, 0);
        check("rst_res_angle", res_angle, 0);
        check("rst_res_cos", res_cos, 0);

        // step > limit: straight to FIN, done two cycles after run
        res_ready = 1'b1;
        s0 = start_cnt;
        start(25'd100, 25'd50);
        check("bad_busy", busy, 1);
        check("bad_done_early", done, 0);
        tick(1);
        check("bad_done", done, 1);
        check("bad_busy_after", busy, 0);
        tick(1);
        check("bad_done_one_cycle", done, 0);
        check("bad_done_latency", 64'(done_cyc - run_cyc), 64'd2);
        check("bad_no_start", 64'(start_cnt - s0), 64'd0);
        check("bad_count", count, 0);

        // zero step also finishes without issuing
        d0 = done_cnt;
        start(25'd0, 25'd100);
        tick(3);
        check("zero_done", 64'(done_cnt - d0), 64'd1);
        check("zero_no_start", 64'(start_cnt - s0), 64'd0);

        // next angle overflows W bits after one result
        got.delete();
        start(25'h1000000, 25'h1FFFFFF);
        wait_done(200, "wrap_done");
        check("wrap_n", 64'(got.size()), 64'd1);
        check("wrap_angle", got[0].angle, 64'h1000000);
        check("wrap_cos", got[0].cos, cos_model(25'h1000000));
        check("wrap_count", count, 1);

        // full sweep, sink always ready, stray run while busy
        got.delete();
        s0 = start_cnt;
        d0 = done_cnt;
        start(25'd8192, 25'd13170114);
        tick(20);
        check("full_busy", busy, 1);
        step_in = 25'd100;
        limit_in = 25'd200;
        run = 1'b1;
        tick(1);
        run = 1'b0;
        wait_done(20000, "full_done");
        check_sweep("full", 1607, 25'd8192);
        check("full_last", got[got.size()-1].angle, 64'd13164544);
        check("full_count", count, 16'd1607);
        check("full_starts", 64'(start_cnt - s0), 64'd1607);
        check("full_one_done", 64'(done_cnt - d0), 64'd1);
        check("full_err", err, 0);

        // stalled sink: four buffered, issuing halts, then drain
        res_ready = 1'b0;
        got.delete();
        s0 = start_cnt;
        start(25'd8192, 25'd13170114);
        tick(200);
        check("stall_starts", 64'(start_cnt - s0), 64'd4);
        check("stall_valid", res_valid, 1);
        check("stall_busy", busy, 1);
        check("stall_head", res_angle, 64'd8192);
        tick(50);
        check("stall_starts_hold", 64'(start_cnt - s0), 64'd4);
        check("stall_head_stable", res_angle, 64'd8192);
        check("stall_cos_stable", res_cos, cos_model(25'd8192));
        res_ready = 1'b1;
        wait_done(20000, "stall_done");
        check_sweep("stall", 1607, 25'd8192);
        check("stall_count", count, 16'd1607);

`ifdef SWEEP_TIMEOUT_EN
        // core never answers: watchdog ends the sweep with err
        hold = 1'b1;
        kick = 1'b0;
        got.delete();
        start(25'd8192, 25'd100000);
        wait_done(300, "tmo_done");
        check("tmo_err", err, 1);
        check("tmo_latency", 64'(done_cyc - start_cyc), 64'd64);
        check("tmo_count", count, 0);
        check("tmo_no_push", 64'(got.size()), 64'd0);
        start(25'd100, 25'd50);
        check("tmo_err_cleared", err, 0);
        tick(4);
        hold = 1'b0;
`endif

        // reset in WAIT coinciding with a core_ready rise
        hold = 1'b1;
        kick = 1'b0;
        got.delete();
        d0 = done_cnt;
        start(25'd8192, 25'd1000000);
        check("rw_core_start", core_start, 1);
        tick(1);
        start_angle = int'(core_angle);
        check("rw_angle", 64'(start_angle), 64'd8192);
        kick = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        kick = 1'b0;
        check("rw_busy", busy, 0);
        check("rw_valid", res_valid, 0);
        check("rw_count", count, 0);
        check("rw_core_angle", core_angle, 0);
        tick(4);
        check("rw_no_done", 64'(done_cnt - d0), 64'd0);
        check("rw_no_push", 64'(got.size()), 64'd0);
        check("rw_still_empty", res_valid, 0);
        hold = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
